// File: rtl/lsu_align_if.sv
// Core-side request/response and word-memory signals of the load/store aligner.
// The aligner connects through the slave modport; the core/memory side uses master.
interface lsu_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wm;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_a, mem_wd, mem_wm
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_a, mem_wd, mem_wm
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store aligner: one request in flight, byte-lane store steering, sign/zero-extended loads.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned or illegal-width requests skip memory and return rsp_err.
module lsu_align #(
    parameter int RD_LATENCY = 1
) (
    input logic        clk,
    input logic        reset,
    lsu_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] SZ_B      = 2'd0;
    localparam logic [1:0] SZ_H      = 2'd1;
    localparam logic [1:0] SZ_W      = 2'd2;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [1:0]  wcnt;
    logic [31:0] rdata_q;
    logic        rerr_q;
    logic        trap_hit;
    logic [1:0]  sz_q;

    // Unknown store widths collapse to word; loads decode on funct3[1:0] with funct3[2] as unsigned.
    function automatic logic [1:0] size_of(input logic we, input logic [2:0] f3);
        logic [1:0] sz;
        sz = SZ_W;
        if (we) begin
            if (f3 == 3'b000)      sz = SZ_B;
            else if (f3 == 3'b001) sz = SZ_H;
        end else begin
            if (f3[1:0] == 2'b00)      sz = SZ_B;
            else if (f3[1:0] == 2'b01) sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size_of(1'b0, f3))
            SZ_B:    r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_trap(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic       illegal;
        logic [1:0] sz;
        illegal = we ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
        sz      = size_of(we, f3);
        return illegal || ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction

    assign trap_hit = is_trap(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    assign sz_q = size_of(we_q, f3_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A trapped request still spends its issue slot (with memory suppressed) so that
    // errors report with the same two-cycle latency as stores.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = (we_q || err_q) ? RESP : WAIT;
            WAIT:    if (wcnt == WAIT_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_a     = '0;
        bus.mem_wd    = '0;
        bus.mem_wm    = '0;
        if (!reset) begin
            bus.req_ready = (state == IDLE);
            bus.rsp_valid = (state == RESP);
            if (((state == ISSUE) || (state == WAIT)) && !err_q)
                bus.mem_a = addr_q;
            if ((state == ISSUE) && we_q && !err_q) begin
                bus.mem_we = 1'b1;
                case (sz_q)
                    SZ_B: begin
                        bus.mem_wm = 4'b0001 << addr_q[1:0];
                        bus.mem_wd = {4{wdata_q[7:0]}};
                    end
                    SZ_H: begin
                        bus.mem_wm = addr_q[1] ? 4'b1100 : 4'b0011;
                        bus.mem_wd = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        bus.mem_wm = 4'b1111;
                        bus.mem_wd = wdata_q;
                    end
                endcase
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rerr_q;

    // Response registers only change on the edge that enters RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wcnt    <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= trap_hit;
            end
            if (state == ISSUE)     wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 2'd1;
            if ((state == ISSUE) && (we_q || err_q)) begin
                rdata_q <= '0;
                rerr_q  <= err_q;
            end
            if ((state == WAIT) && (wcnt == WAIT_LAST)) begin
                rdata_q <= extract(f3_q, addr_q[1:0], bus.mem_rd);
                rerr_q  <= 1'b0;
            end
        end
    end
endmodule
